// File: rtl/uart_var_rx.sv
// 8N1 UART receiver with a runtime baud rate latched at each start edge.
// Two-flop synchroniser, mid-bit start validation, centre sampling, one-cycle strobes.
module uart_var_rx #(
  parameter int clock_freq  = 100_000_000,
  parameter int baud_width  = 20,
  parameter int limit_width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [baud_width-1:0] baud_var,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [31:0] clk_q     = 32'(clock_freq);
  localparam logic [31:0] limit_max = 32'((64'd1 << limit_width) - 64'd1);
  localparam logic [31:0] limit_min = 32'd4;

  state_t                 state_r;
  logic                   sync1_r, sync2_r, prev_r;
  logic [limit_width-1:0] cnt_r, limit_r, half_r;
  logic [2:0]             bit_idx_r;
  logic [7:0]             shift_r;
  logic [31:0]            baud32_s, quot_s;
  logic [limit_width-1:0] limit_s;
  logic                   rate_ok_s, start_edge_s;

  // Rates too fast for a 4-clock bit, or too slow for the counter, keep the block idle.
  assign baud32_s     = 32'(baud_var);
  assign quot_s       = (baud32_s == 32'd0) ? 32'd0 : clk_q / baud32_s;
  assign limit_s      = quot_s[limit_width-1:0];
  assign rate_ok_s    = (quot_s >= limit_min) && (quot_s <= limit_max);
  assign start_edge_s = prev_r && !sync2_r;

  // Metastability synchroniser plus edge-detect flop, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      limit_r   <= '0;
      half_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (start_edge_s && rate_ok_s) begin
            limit_r <= limit_s;
            half_r  <= limit_s >> 1;
            state_r <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == half_r - limit_width'(1)) begin
            cnt_r <= '0;
            if (!sync2_r) begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + limit_width'(1);
          end
        end
        DATA: begin
          if (cnt_r == limit_r - limit_width'(1)) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + limit_width'(1);
          end
        end
        STOP: begin
          if (cnt_r == limit_r - limit_width'(1)) begin
            cnt_r   <= '0;
            state_r <= IDLE;
            rx_busy <= 1'b0;
            if (sync2_r) begin
              rx_data  <= shift_r;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + limit_width'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
